// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-queue round-robin buffer:
// queue-id width and the rotating-priority grant function.
package fifo_pkg;

    localparam int MAX_Q = 32;

    function automatic int qid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot grant to the first requester after 'last', wrapping modulo nq.
    function automatic logic [MAX_Q-1:0] rr_pick(input logic [MAX_Q-1:0] req,
                                                 input int last,
                                                 input int nq);
        logic [MAX_Q-1:0] gnt;
        logic             found;
        int               idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= nq; k++) begin
            idx = (last + k) % nq;
            if (!found && req[idx[4:0]]) begin
                gnt[idx[4:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Per-queue FIFO bookkeeping: full/empty flags and next pointer/count values.
// Purely combinational; the owning block holds the registers.
module fifo_ctrl #(
    parameter int ADDR_BW = 2
) (
    input  logic               wr_din,
    input  logic               rd_dout,
    input  logic [ADDR_BW-1:0] wrptr,
    input  logic [ADDR_BW-1:0] rdptr,
    input  logic [ADDR_BW:0]   numitem,
    output logic [ADDR_BW-1:0] next_wrptr,
    output logic [ADDR_BW-1:0] next_rdptr,
    output logic [ADDR_BW:0]   next_numitem,
    output logic               full,
    output logic               empty,
    output logic               wr_ok,
    output logic               wr_rej
);

    localparam logic [ADDR_BW:0] DEPTH = {1'b1, {ADDR_BW{1'b0}}};

    logic rd_ok;

    assign full   = (numitem == DEPTH);
    assign empty  = (numitem == '0);
    assign wr_ok  = wr_din & ~full;
    assign wr_rej = wr_din & full;
    assign rd_ok  = rd_dout & ~empty;

    assign next_wrptr = wr_ok ? wrptr + ADDR_BW'(1) : wrptr;
    assign next_rdptr = rd_ok ? rdptr + ADDR_BW'(1) : rdptr;

    always_comb begin
        next_numitem = numitem;
        case ({wr_ok, rd_ok})
            2'b10:   next_numitem = numitem + (ADDR_BW+1)'(1);
            2'b01:   next_numitem = numitem - (ADDR_BW+1)'(1);
            default: next_numitem = numitem;
        endcase
    end

endmodule

// File: rtl/fifo_rr_sched.sv
// NUM_Q parallel-push FIFOs drained one item per cycle into a registered
// valid/ready output stage, chosen in round-robin order.
module fifo_rr_sched
    import fifo_pkg::*;
#(
    parameter int NUM_Q   = 4,
    parameter int DATA_BW = 8,
    parameter int ADDR_BW = 2,
    localparam int QID_BW = qid_width(NUM_Q)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_Q-1:0]         wr_en,
    input  logic [NUM_Q*DATA_BW-1:0] wr_data,
    output logic [NUM_Q-1:0]         full,
    output logic [NUM_Q-1:0]         empty,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_BW-1:0]       out_data,
    output logic [QID_BW-1:0]        out_qid,
    output logic [NUM_Q-1:0]         ovf_err
);

    localparam int DEPTH = 1 << ADDR_BW;

    logic [NUM_Q-1:0][DATA_BW-1:0] head_data;
    logic [NUM_Q-1:0]              grant;
    logic [MAX_Q-1:0]              req_ext;
    logic [MAX_Q-1:0]              gnt_ext;
    logic                          load;
    logic                          any_grant;
    logic [DATA_BW-1:0]            sel_data;
    logic [QID_BW-1:0]             sel_qid;

    logic                          vld_p1;
    logic [DATA_BW-1:0]            data_p1;
    logic [QID_BW-1:0]             qid_p1;
    logic [QID_BW-1:0]             rr_last;

    for (genvar i = 0; i < NUM_Q; i++) begin : g_q
        logic [ADDR_BW-1:0] wr_ptr;
        logic [ADDR_BW-1:0] rd_ptr;
        logic [ADDR_BW:0]   cnt;
        logic [ADDR_BW-1:0] nxt_wr_ptr;
        logic [ADDR_BW-1:0] nxt_rd_ptr;
        logic [ADDR_BW:0]   nxt_cnt;
        logic               wr_ok;
        logic               wr_rej;
        logic               ovf;
        logic [DATA_BW-1:0] mem [DEPTH];

        fifo_ctrl #(
            .ADDR_BW (ADDR_BW)
        ) u_ctrl (
            .wr_din       (wr_en[i]),
            .rd_dout      (grant[i]),
            .wrptr        (wr_ptr),
            .rdptr        (rd_ptr),
            .numitem      (cnt),
            .next_wrptr   (nxt_wr_ptr),
            .next_rdptr   (nxt_rd_ptr),
            .next_numitem (nxt_cnt),
            .full         (full[i]),
            .empty        (empty[i]),
            .wr_ok        (wr_ok),
            .wr_rej       (wr_rej)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                ovf    <= 1'b0;
            end else if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                ovf    <= 1'b0;
            end else begin
                wr_ptr <= nxt_wr_ptr;
                rd_ptr <= nxt_rd_ptr;
                cnt    <= nxt_cnt;
                ovf    <= ovf | wr_rej;
            end
        end

        // Storage is left uncleared by reset and flush; pointers alone define contents.
        always_ff @(posedge clk) begin
            if (wr_ok && !flush)
                mem[wr_ptr] <= wr_data[i*DATA_BW +: DATA_BW];
        end

        assign head_data[i] = mem[rd_ptr];
        assign ovf_err[i]   = ovf;
    end

    // Arbitration stage: only pick a queue when the output stage can take it.
    assign load = ~vld_p1 | out_ready;

    always_comb begin
        req_ext            = '0;
        req_ext[NUM_Q-1:0] = ~empty;
    end

    assign gnt_ext   = rr_pick(req_ext, int'(rr_last), NUM_Q);
    assign grant     = load ? gnt_ext[NUM_Q-1:0] : '0;
    assign any_grant = |grant;

    always_comb begin
        sel_data = '0;
        sel_qid  = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (grant[i]) begin
                sel_data = head_data[i];
                sel_qid  = QID_BW'(i);
            end
        end
    end

    // Output stage p1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            qid_p1  <= '0;
            rr_last <= QID_BW'(NUM_Q - 1);
        end else if (flush) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            qid_p1  <= '0;
            rr_last <= QID_BW'(NUM_Q - 1);
        end else if (load) begin
            if (any_grant) begin
                vld_p1  <= 1'b1;
                data_p1 <= sel_data;
                qid_p1  <= sel_qid;
                rr_last <= sel_qid;
            end else begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_qid   = qid_p1;

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed bench for fifo_rr_sched: expected outputs are queued by the stimulus
// and consumed by an independent output monitor.
module tb_fifo_rr_sched;

    localparam int NQ = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [NQ-1:0]   wr_en = '0;
    logic [NQ*DW-1:0] wr_data = '0;
    logic [NQ-1:0]   full;
    logic [NQ-1:0]   empty;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_qid;
    logic [NQ-1:0]   ovf_err;

    int              total = 0;
    int              bad = 0;
    logic [9:0]      sb[$];
    logic [9:0]      exp_item;

    always #5 clk = ~clk;

    fifo_rr_sched #(
        .NUM_Q   (NQ),
        .DATA_BW (DW),
        .ADDR_BW (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_qid   (out_qid),
        .ovf_err   (ovf_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int q, input logic [7:0] d);
        wr_en[q]          = 1'b1;
        wr_data[q*DW +: DW] = d;
    endtask

    task automatic expect_out(input int q, input logic [7:0] d);
        sb.push_back({q[1:0], d});
    endtask

    task automatic do_flush();
        wr_en = '0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got qid=%0d data=%0h expected nothing", out_qid, out_data);
            end else begin
                exp_item = sb.pop_front();
                if ({out_qid, out_data} !== exp_item) begin
                    bad++;
                    $display("FAIL out_item: got qid=%0d data=%0h expected qid=%0d data=%0h",
                             out_qid, out_data, exp_item[9:8], exp_item[7:0]);
                end
            end
        end
    end

    initial begin
        // Reset then idle
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("idle_valid", 32'(out_valid), 0);
            chk("idle_empty", 32'(empty), 'hF);
            chk("idle_full",  32'(full), 0);
            chk("idle_ovf",   32'(ovf_err), 0);
            step();
        end

        // Single push latency
        do_flush();
        out_ready = 1'b1;
        push(2, 8'hA1);
        expect_out(2, 8'hA1);
        step();
        wr_en = '0;
        chk("lat_t1_valid", 32'(out_valid), 0);
        step();
        chk("lat_t2_valid", 32'(out_valid), 1);
        chk("lat_t2_data",  32'(out_data), 'hA1);
        chk("lat_t2_qid",   32'(out_qid), 2);
        step();
        chk("lat_t3_valid", 32'(out_valid), 0);

        // Round-robin order across three queues
        out_ready = 1'b0;
        do_flush();
        push(0, 8'h10); push(1, 8'h20); push(3, 8'h30);
        step();
        wr_en = '0;
        push(0, 8'h11); push(3, 8'h31);
        step();
        wr_en = '0;
        step(2);
        chk("rr_head_data", 32'(out_data), 'h10);
        expect_out(0, 8'h10); expect_out(1, 8'h20); expect_out(3, 8'h30);
        expect_out(0, 8'h11); expect_out(3, 8'h31);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rr_stream_valid", 32'(out_valid), 1);
            step();
        end
        chk("rr_done_valid", 32'(out_valid), 0);

        // Overflow on q1 while output stage is held
        out_ready = 1'b0;
        do_flush();
        push(0, 8'h55);
        step();
        wr_en = '0;
        step();
        chk("ovf_hold_valid", 32'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            push(1, 8'(8'h40 + k));
            step();
            if (k == 3) begin
                chk("ovf_full4", 32'(full), 'h2);
                chk("ovf_none4", 32'(ovf_err), 0);
            end
        end
        wr_en = '0;
        chk("ovf_err5",  32'(ovf_err), 'h2);
        chk("ovf_full5", 32'(full), 'h2);
        expect_out(0, 8'h55);
        for (int k = 0; k < 4; k++) expect_out(1, 8'(8'h40 + k));
        out_ready = 1'b1;
        step(7);
        chk("ovf_drained_empty", 32'(empty), 'hF);
        chk("ovf_sticky", 32'(ovf_err), 'h2);

        // Backpressure hold
        out_ready = 1'b0;
        do_flush();
        push(2, 8'h70); step();
        push(2, 8'h71); step();
        push(2, 8'h72); step();
        wr_en = '0;
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data",  32'(out_data), 'h70);
            chk("bp_qid",   32'(out_qid), 2);
            chk("bp_empty", 32'(empty), 'hB);
            chk("bp_full",  32'(full), 0);
            step();
        end
        expect_out(2, 8'h70); expect_out(2, 8'h71); expect_out(2, 8'h72);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_release_valid", 32'(out_valid), 1);
            step();
        end
        chk("bp_release_done", 32'(out_valid), 0);

        // Flush mid-stream with q0, q1, q3 loaded and an overflow recorded
        out_ready = 1'b0;
        do_flush();
        push(0, 8'h80); push(1, 8'h90); push(3, 8'hB0); step();
        wr_en = '0;
        push(0, 8'h81); push(1, 8'h91); push(3, 8'hB1); step();
        wr_en = '0;
        push(1, 8'h92); step();
        push(1, 8'h93); step();
        push(1, 8'h94); step();
        wr_en = '0;
        chk("fl_pre_ovf",   32'(ovf_err), 'h2);
        chk("fl_pre_empty", 32'(empty), 'h4);
        chk("fl_pre_valid", 32'(out_valid), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", 32'(out_valid), 0);
        chk("fl_empty", 32'(empty), 'hF);
        chk("fl_ovf",   32'(ovf_err), 0);
        chk("fl_full",  32'(full), 0);
        out_ready = 1'b1;
        push(3, 8'hC3);
        expect_out(3, 8'hC3);
        step();
        wr_en = '0;
        chk("fl_next_t1", 32'(out_valid), 0);
        step();
        chk("fl_next_valid", 32'(out_valid), 1);
        chk("fl_next_qid",   32'(out_qid), 3);
        chk("fl_next_data",  32'(out_data), 'hC3);
        step();

        // Pointer wrap through q0 at full rate
        do_flush();
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            push(0, 8'(8'hD0 + k));
            expect_out(0, 8'(8'hD0 + k));
            step();
        end
        wr_en = '0;
        step(4);
        chk("wrap_empty", 32'(empty), 'hF);

        // Asynchronous reset while an item is held
        out_ready = 1'b0;
        push(2, 8'hEE);
        step();
        wr_en = '0;
        step(2);
        chk("ar_pre_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_empty", 32'(empty), 'hF);
        chk("ar_data",  32'(out_data), 0);
        step();
        rst_n = 1'b1;
        step(2);
        chk("ar_post_valid", 32'(out_valid), 0);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
